// File: rtl/lbp_3x3.sv
// lbp_3x3 -- 3x3 local binary pattern filter for a streaming RGB video path.
//
// Converts each valid pixel to grey, keeps the two previous lines in line
// buffers, and forms a 3x3 window whose centre lags the newest pixel by one
// row and one column. Each output carries the 8-bit LBP code of that window
// (bit set when neighbour >= centre) on all three colour channels, with a
// fixed 3-clock latency. Window positions that touch the frame border, pixels
// beyond MAX_WIDTH and lines received before the first VSync after a reset
// produce code 0.
//
// Optional feature: define LBP_BYPASS_EN to add input iBypass; when it is 1
// the outputs carry the window-centre grey level instead of the code.
//
// Ports:
//   iClk                      clock, rising edge
//   iRst                      synchronous reset, active low
//   iBypass                   (LBP_BYPASS_EN only) output grey instead of code
//   iHSync/iVSync/iDataValid  input video timing
//   iR/iG/iB                  input pixel colour, qualified by iDataValid
//   oR/oG/oB                  LBP code (or grey), identical on all channels
//   oHSync/oVSync/oDataValid  input timing delayed by 3 clocks
module lbp_3x3 #(
  parameter int MAX_WIDTH = 1024
) (
  input  logic       iClk,
  input  logic       iRst,
`ifdef LBP_BYPASS_EN
  input  logic       iBypass,
`endif
  input  logic       iHSync,
  input  logic       iVSync,
  input  logic       iDataValid,
  input  logic [7:0] iR,
  input  logic [7:0] iG,
  input  logic [7:0] iB,
  output logic [7:0] oR,
  output logic [7:0] oG,
  output logic [7:0] oB,
  output logic       oHSync,
  output logic       oVSync,
  output logic       oDataValid
);

  localparam int DATA_W = 8;
  localparam int COL_W  = $clog2(MAX_WIDTH + 1);
  localparam int ADDR_W = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam int ROW_W  = 10;
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(MAX_WIDTH);
  localparam logic [ROW_W-1:0] ROW_MAX = '1;

  function automatic logic [DATA_W-1:0] toGrey(input logic [7:0] r,
                                                input logic [7:0] g,
                                                input logic [7:0] b);
    logic [9:0] sum;
    sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
    return sum[9:2];
  endfunction

  function automatic logic [COL_W-1:0] colSat(input logic [COL_W-1:0] c);
    return (c == COL_MAX) ? c : c + COL_W'(1);
  endfunction

  function automatic logic [ROW_W-1:0] rowSat(input logic [ROW_W-1:0] r);
    return (r == ROW_MAX) ? r : r + ROW_W'(1);
  endfunction

  function automatic logic [DATA_W-1:0] lbpCode(
    input logic [DATA_W-1:0] tl, input logic [DATA_W-1:0] t,
    input logic [DATA_W-1:0] tr, input logic [DATA_W-1:0] r,
    input logic [DATA_W-1:0] br, input logic [DATA_W-1:0] b,
    input logic [DATA_W-1:0] bl, input logic [DATA_W-1:0] l,
    input logic [DATA_W-1:0] c);
    return {tl >= c, t >= c, tr >= c, r >= c, br >= c, b >= c, bl >= c, l >= c};
  endfunction

  // Line/frame position tracking
  logic [COL_W-1:0]  colCnt;
  logic [ROW_W-1:0]  rowCnt;
  logic              dvPrev;
  logic              frameSynced;   // a VSync has been seen since reset
  logic [ROW_W-1:0]  pixRow;
  logic              border;

  // A pixel arriving together with VSync already belongs to row 0.
  assign pixRow = iVSync ? '0 : rowCnt;
  assign border = !(frameSynced || iVSync) || (pixRow < ROW_W'(2)) ||
                  (colCnt < COL_W'(2)) || (colCnt >= COL_MAX);

  // ---- stage 1: grey conversion, position and border flag ----
  logic [DATA_W-1:0] grey_p1;
  logic [COL_W-1:0]  col_p1;
  logic              border_p1, vld_p1, hs_p1, vs_p1;

  always_ff @(posedge iClk) begin
    if (!iRst) begin
      colCnt      <= '0;
      rowCnt      <= '0;
      dvPrev      <= 1'b0;
      frameSynced <= 1'b0;
      grey_p1     <= '0;
      col_p1      <= '0;
      border_p1   <= 1'b0;
      vld_p1      <= 1'b0;
      hs_p1       <= 1'b0;
      vs_p1       <= 1'b0;
    end else begin
      dvPrev <= iDataValid;
      if (iDataValid)  colCnt <= colSat(colCnt);
      else if (dvPrev) colCnt <= '0;
      if (iVSync)                    rowCnt <= '0;
      else if (dvPrev && !iDataValid) rowCnt <= rowSat(rowCnt);
      if (iVSync) frameSynced <= 1'b1;
      grey_p1   <= toGrey(iR, iG, iB);
      col_p1    <= colCnt;
      border_p1 <= border;
      vld_p1    <= iDataValid;
      hs_p1     <= iHSync;
      vs_p1     <= iVSync;
    end
  end

  // ---- stage 2: line buffers and window shift ----
  logic [DATA_W-1:0] lineBuf0 [MAX_WIDTH];   // previous line
  logic [DATA_W-1:0] lineBuf1 [MAX_WIDTH];   // line before that
  logic [ADDR_W-1:0] lbAddr;
  logic              lbInRange;
  logic [DATA_W-1:0] lb0Rd, lb1Rd;

  assign lbAddr    = col_p1[ADDR_W-1:0];
  assign lbInRange = (col_p1 < COL_MAX);
  // Combinational read returns the pre-write contents of this cycle.
  assign lb0Rd     = lbInRange ? lineBuf0[lbAddr] : '0;
  assign lb1Rd     = lbInRange ? lineBuf1[lbAddr] : '0;

  always_ff @(posedge iClk) begin
    if (vld_p1 && lbInRange) begin
      lineBuf0[lbAddr] <= grey_p1;
      lineBuf1[lbAddr] <= lineBuf0[lbAddr];
    end
  end

  // win[row][col]: row 0 oldest line, col 2 newest pixel; centre is win[1][1].
  logic [DATA_W-1:0] win [3][3];
  logic              border_p2, vld_p2, hs_p2, vs_p2;

  always_ff @(posedge iClk) begin
    if (!iRst) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= '0;
      border_p2 <= 1'b0;
      vld_p2    <= 1'b0;
      hs_p2     <= 1'b0;
      vs_p2     <= 1'b0;
    end else begin
      if (vld_p1) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= lb1Rd;
        win[1][2] <= lb0Rd;
        win[2][2] <= grey_p1;
      end
      border_p2 <= border_p1;
      vld_p2    <= vld_p1;
      hs_p2     <= hs_p1;
      vs_p2     <= vs_p1;
    end
  end

  // ---- stage 3: code, border masking and output register ----
  logic              useGrey;
  logic [DATA_W-1:0] code, result;

`ifdef LBP_BYPASS_EN
  assign useGrey = iBypass;
`else
  assign useGrey = 1'b0;
`endif

  assign code   = lbpCode(win[0][0], win[0][1], win[0][2], win[1][2],
                          win[2][2], win[2][1], win[2][0], win[1][0], win[1][1]);
  assign result = border_p2 ? '0 : (useGrey ? win[1][1] : code);

  logic [DATA_W-1:0] pix_p3;
  logic              vld_p3, hs_p3, vs_p3;

  always_ff @(posedge iClk) begin
    if (!iRst) begin
      pix_p3 <= '0;
      vld_p3 <= 1'b0;
      hs_p3  <= 1'b0;
      vs_p3  <= 1'b0;
    end else begin
      pix_p3 <= vld_p2 ? result : '0;
      vld_p3 <= vld_p2;
      hs_p3  <= hs_p2;
      vs_p3  <= vs_p2;
    end
  end

  assign oR         = pix_p3;
  assign oG         = pix_p3;
  assign oB         = pix_p3;
  assign oHSync     = hs_p3;
  assign oVSync     = vs_p3;
  assign oDataValid = vld_p3;

endmodule

// File: tb/tb_lbp_3x3.sv
// tb_lbp_3x3 -- directed testbench for lbp_3x3 (MAX_WIDTH = 8).
// Drives small frames from per-pixel colour tables, logs every output cycle,
// then checks selected output pixels against hand-computed codes.
module tb_lbp_3x3;

  localparam int MW   = 8;
  localparam int LOGN = 4096;

  logic       iClk = 1'b0;
  logic       iRst = 1'b0;
  logic       iHSync = 1'b0, iVSync = 1'b0, iDataValid = 1'b0;
  logic [7:0] iR = '0, iG = '0, iB = '0;
  logic [7:0] oR, oG, oB;
  logic       oHSync, oVSync, oDataValid;
`ifdef LBP_BYPASS_EN
  logic       iBypass = 1'b0;
`endif

  lbp_3x3 #(.MAX_WIDTH(MW)) dut (
    .iClk(iClk), .iRst(iRst),
`ifdef LBP_BYPASS_EN
    .iBypass(iBypass),
`endif
    .iHSync(iHSync), .iVSync(iVSync), .iDataValid(iDataValid),
    .iR(iR), .iG(iG), .iB(iB),
    .oR(oR), .oG(oG), .oB(oB),
    .oHSync(oHSync), .oVSync(oVSync), .oDataValid(oDataValid)
  );

  always #5 iClk = ~iClk;

  logic [7:0] logR [LOGN];
  logic [7:0] logG [LOGN];
  logic [7:0] logB [LOGN];
  logic       logV [LOGN];
  logic       logH [LOGN];
  logic       logVs[LOGN];
  int         n = 0;
  int         nCmp = 0, nErr = 0;
  int         vsN = 0, rstN = 0;

  logic [7:0] imgR [4][12];
  logic [7:0] imgG [4][12];
  logic [7:0] imgB [4][12];
  int         pixN [4][12];

  // Log outputs from the previous edge, then apply the next input cycle.
  task automatic drive(input logic rst, input logic vs, input logic hs,
                       input logic dv, input logic [7:0] r,
                       input logic [7:0] g, input logic [7:0] b);
    @(negedge iClk);
    if (n < LOGN) begin
      logR[n] = oR; logG[n] = oG; logB[n] = oB;
      logV[n] = oDataValid; logH[n] = oHSync; logVs[n] = oVSync;
    end
    iRst = rst; iVSync = vs; iHSync = hs; iDataValid = dv;
    iR = r; iG = g; iB = b;
    n++;
  endtask

  task automatic idle(input int k);
    repeat (k) drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
  endtask

  task automatic vsyncPulse();
    vsN = n;
    repeat (2) drive(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    idle(2);
  endtask

  task automatic sendLine(input int r, input int c0, input int c1, input int gap);
    for (int c = c0; c < c1; c++) begin
      pixN[r][c] = n;
      drive(1'b1, 1'b0, 1'b0, 1'b1, imgR[r][c], imgG[r][c], imgB[r][c]);
    end
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    idle(gap - 1);
  endtask

  task automatic sendFrame(input int w, input int h, input int gap);
    vsyncPulse();
    for (int r = 0; r < h; r++) sendLine(r, 0, w, gap);
    idle(4);
  endtask

  task automatic fillFlat(input logic [7:0] v);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 12; c++) begin
        imgR[r][c] = v; imgG[r][c] = v; imgB[r][c] = v;
      end
  endtask

  task automatic setPix(input int r, input int c, input logic [7:0] rv,
                        input logic [7:0] gv, input logic [7:0] bv);
    imgR[r][c] = rv; imgG[r][c] = gv; imgB[r][c] = bv;
  endtask

  // Output of pixel (r,c) appears three edges after it was applied.
  task automatic chkPix(input string tag, input int r, input int c,
                        input logic [7:0] exp);
    int k;
    k = pixN[r][c] + 3;
    nCmp++;
    assert ({logV[k], logR[k], logG[k], logB[k]} === {1'b1, exp, exp, exp})
    else begin
      nErr++;
      $error("FAIL %s: observed v=%0b rgb=%02h/%02h/%02h, expected v=1 rgb=%02h",
             tag, logV[k], logR[k], logG[k], logB[k], exp);
    end
  endtask

  task automatic chkBit(input string tag, input logic obs, input logic exp);
    nCmp++;
    assert (obs === exp)
    else begin
      nErr++;
      $error("FAIL %s: observed %0b, expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chkByte(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
    nCmp++;
    assert (obs === exp)
    else begin
      nErr++;
      $error("FAIL %s: observed %02h, expected %02h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset with active-looking inputs: everything must read zero.
    repeat (3) drive(1'b0, 1'b1, 1'b1, 1'b1, 8'd55, 8'd55, 8'd55);
    idle(1);
    chkBit("rst_valid", logV[n-1], 1'b0);
    chkByte("rst_pix", logR[n-1] | logG[n-1] | logB[n-1], 8'h00);
    chkBit("rst_sync", logH[n-1] | logVs[n-1], 1'b0);

    // Flat grey 100 frame.
    fillFlat(8'd100);
    sendFrame(8, 4, 1);
    chkBit("lat_first_v", logV[pixN[0][0] + 3], 1'b1);
    chkBit("lat_early_v", logV[pixN[0][0] + 2], 1'b0);
    chkBit("vs_delay_on", logVs[vsN + 3], 1'b1);
    chkBit("vs_delay_off", logVs[vsN + 2], 1'b0);
    chkBit("hs_delay", logH[pixN[0][7] + 4], 1'b1);
    chkPix("flat_r0", 0, 5, 8'h00);
    chkPix("flat_r1", 1, 4, 8'h00);
    chkPix("flat_c0", 2, 0, 8'h00);
    chkPix("flat_c1", 2, 1, 8'h00);
    chkPix("flat_22", 2, 2, 8'hFF);
    chkPix("flat_37", 3, 7, 8'hFF);
    chkBit("blank_v", logV[pixN[3][7] + 4], 1'b0);
    chkByte("blank_pix", logR[pixN[3][7] + 4], 8'h00);

    // Centre 50, T=51, L=50, others 49.
    fillFlat(8'd49);
    setPix(1, 1, 8'd50, 8'd50, 8'd50);
    setPix(0, 1, 8'd51, 8'd51, 8'd51);
    setPix(1, 0, 8'd50, 8'd50, 8'd50);
    sendFrame(8, 4, 1);
    chkPix("pat_22", 2, 2, 8'h41);
    chkPix("pat_23", 2, 3, 8'hFF);
    chkPix("pat_21", 2, 1, 8'h00);

    // Same frame with long blanking between lines.
    sendFrame(8, 4, 5);
    chkPix("gap_22", 2, 2, 8'h41);
    chkPix("gap_23", 2, 3, 8'hFF);
    chkPix("gap_32", 3, 2, 8'hFF);

    // Colour centre (255,0,1) -> grey 64; T=64, others 63.
    fillFlat(8'd63);
    setPix(1, 1, 8'd255, 8'd0, 8'd1);
    setPix(0, 1, 8'd64, 8'd64, 8'd64);
    sendFrame(8, 4, 1);
    chkPix("col_22", 2, 2, 8'h40);
    chkPix("col_23", 2, 3, 8'hFF);
`ifdef LBP_BYPASS_EN
    iBypass = 1'b1;
    sendFrame(8, 4, 1);
    chkPix("byp_22", 2, 2, 8'd64);
    chkPix("byp_23", 2, 3, 8'd63);
    chkPix("byp_12", 1, 2, 8'd0);
    iBypass = 1'b0;
`endif

    // 12-pixel lines into 8-entry buffers; tail pixels are low-valued.
    fillFlat(8'd100);
    for (int r = 0; r < 4; r++)
      for (int c = 8; c < 12; c++) setPix(r, c, 8'd10, 8'd10, 8'd10);
    sendFrame(12, 4, 1);
    chkPix("wide_27", 2, 7, 8'hFF);
    chkPix("wide_28", 2, 8, 8'h00);
    chkPix("wide_211", 2, 11, 8'h00);
    chkPix("wide_32", 3, 2, 8'hFF);
    chkPix("wide_35", 3, 5, 8'hFF);
    chkPix("wide_39", 3, 9, 8'h00);

    // Reset in the middle of row 2 of a flat frame.
    fillFlat(8'd100);
    vsyncPulse();
    sendLine(0, 0, 8, 1);
    sendLine(1, 0, 8, 1);
    for (int c = 0; c < 6; c++) begin
      pixN[2][c] = n;
      drive(1'b1, 1'b0, 1'b0, 1'b1, 8'd100, 8'd100, 8'd100);
    end
    rstN = n;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    idle(2);
    chkBit("mrst_v1", logV[rstN + 1], 1'b0);
    chkByte("mrst_pix1", logR[rstN + 1] | logG[rstN + 1] | logB[rstN + 1], 8'h00);
    chkByte("mrst_pix2", logR[rstN + 2], 8'h00);
    // Three more lines with no VSync: still masked.
    sendLine(0, 0, 8, 1);
    sendLine(1, 0, 8, 1);
    sendLine(2, 0, 8, 1);
    idle(4);
    chkPix("nosync_24", 2, 4, 8'h00);
    chkPix("nosync_27", 2, 7, 8'h00);
    // After VSync: first two lines zero, then normal codes.
    idle(2);
    sendFrame(8, 4, 1);
    chkPix("resync_04", 0, 4, 8'h00);
    chkPix("resync_14", 1, 4, 8'h00);
    chkPix("resync_24", 2, 4, 8'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no completion, expected finish within 500000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
